// File: rtl/div_controller_pkg.sv
// div_ctrl_pkg: shared types for the restoring-division controller.
//   div_state_t : FSM state encoding (3-bit)
//   div_ctrl_t  : bundle of datapath control strobes
//   DEF_WIDTH   : default operand width
package div_ctrl_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_SUB   = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } div_state_t;

    typedef struct packed {
        logic ld_m;
        logic ld_q;
        logic clr_a;
        logic shift_aq;
        logic sub_a;
        logic restore_a;
        logic set_q0;
    } div_ctrl_t;

endpackage

// File: rtl/div_controller_iter_counter.sv
// iter_counter: CW-bit down counter for the division iteration count.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (takes priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; saturates at 0 so it never wraps
//   is_one    : count currently equals 1 (last iteration)
module iter_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          is_one
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign is_one = (cnt == CW'(1));

endmodule

// File: rtl/div_controller.sv
// div_controller: sequencing FSM for a restoring-division datapath.
//   clk, rst      : clock, synchronous active-high reset
//   start         : division request, accepted only in IDLE
//   divisor_zero  : divisor bus is zero; sampled together with start
//   a_msb         : sign of A after subtraction; used in CHECK only
//   ld_m, ld_q, clr_a, shift_aq, sub_a, restore_a, set_q0 : datapath strobes
//   busy          : controller not idle
//   done          : one-cycle completion pulse
//   dbz           : registered divide-by-zero flag, held until next start
module div_controller
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic divisor_zero,
    input  logic a_msb,
    output logic ld_m,
    output logic ld_q,
    output logic clr_a,
    output logic shift_aq,
    output logic sub_a,
    output logic restore_a,
    output logic set_q0,
    output logic busy,
    output logic done,
    output logic dbz
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t state, state_next;
    div_ctrl_t  ctrl;
    logic       cnt_load, cnt_dec, cnt_is_one;

    iter_counter #(.CW(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CW'(WIDTH)),
        .dec      (cnt_dec),
        .is_one   (cnt_is_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            dbz   <= 1'b0;
        end else begin
            state <= state_next;
            // an accepted start both clears and sets the flag in one place
            if (state == ST_IDLE && start)
                dbz <= divisor_zero;
        end
    end

    always_comb begin
        state_next = state;
        ctrl       = '0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                // zero divisor skips the datapath entirely
                if (start)
                    state_next = divisor_zero ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                ctrl.ld_m  = 1'b1;
                ctrl.ld_q  = 1'b1;
                ctrl.clr_a = 1'b1;
                cnt_load   = 1'b1;
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                ctrl.shift_aq = 1'b1;
                state_next    = ST_SUB;
            end
            ST_SUB: begin
                ctrl.sub_a = 1'b1;
                state_next = ST_CHECK;
            end
            ST_CHECK: begin
                // negative partial remainder: undo the subtract, quotient bit stays 0
                if (a_msb)
                    ctrl.restore_a = 1'b1;
                else
                    ctrl.set_q0 = 1'b1;
                cnt_dec    = 1'b1;
                state_next = cnt_is_one ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign ld_m      = ctrl.ld_m;
    assign ld_q      = ctrl.ld_q;
    assign clr_a     = ctrl.clr_a;
    assign shift_aq  = ctrl.shift_aq;
    assign sub_a     = ctrl.sub_a;
    assign restore_a = ctrl.restore_a;
    assign set_q0    = ctrl.set_q0;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_div_controller.sv
// tb_div_controller: directed, table-driven check of div_controller (WIDTH=4)
// with a small 4-bit register datapath model for the integration cases.
module tb_div_controller;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, divisor_zero = 1'b0, am_drv = 1'b0;
    logic a_msb;
    logic ld_m, ld_q, clr_a, shift_aq, sub_a, restore_a, set_q0, busy, done, dbz;

    always #5 clk = ~clk;

    div_controller #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .divisor_zero(divisor_zero),
        .a_msb(a_msb), .ld_m(ld_m), .ld_q(ld_q), .clr_a(clr_a),
        .shift_aq(shift_aq), .sub_a(sub_a), .restore_a(restore_a),
        .set_q0(set_q0), .busy(busy), .done(done), .dbz(dbz)
    );

    // datapath model: A carries an extra sign bit so A-M can go negative
    logic         use_dp = 1'b0;
    logic [W-1:0] dvd_bus = '0, dsr_bus = '0;
    logic [W:0]   dp_a = '0;
    logic [W-1:0] dp_q = '0, dp_m = '0;

    assign a_msb = use_dp ? dp_a[W] : am_drv;

    always @(posedge clk) begin
        if (ld_m)      dp_m <= dsr_bus;
        if (ld_q)      dp_q <= dvd_bus;
        if (clr_a)     dp_a <= '0;
        if (shift_aq)  {dp_a, dp_q} <= {dp_a, dp_q} << 1;
        if (sub_a)     dp_a <= dp_a - {1'b0, dp_m};
        if (restore_a) dp_a <= dp_a + {1'b0, dp_m};
        if (set_q0)    dp_q[0] <= 1'b1;
    end

    wire [6:0] ctrl_o = {ld_m, ld_q, clr_a, shift_aq, sub_a, restore_a, set_q0};
    wire [9:0] obs    = {ctrl_o, busy, done, dbz};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // one cycle: inputs change after the falling edge, outputs sampled 1ns later
    task automatic drive(input logic r, input logic s, input logic z, input logic a);
        @(negedge clk);
        rst = r; start = s; divisor_zero = z; am_drv = a;
        #1;
    endtask

    // caller has just driven cycle 0 with start; counts cycles until done
    task automatic wait_done(input string nm, input int exp_cyc);
        bit found = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            if (done) begin
                chk(nm, 32'(i), 32'(exp_cyc));
                found = 1'b1;
                break;
            end
        end
        if (!found) chk({nm, "_timeout"}, 32'(0), 32'(1));
    endtask

    typedef struct {
        logic       r, s, z, a;
        logic [6:0] ctrl;
        logic       busy, done, dbz;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic s, input logic z, input logic a,
                               input logic [6:0] c, input logic b, input logic d, input logic e);
        vec_t t;
        t.r = r; t.s = s; t.z = z; t.a = a; t.ctrl = c; t.busy = b; t.done = d; t.dbz = e;
        return t;
    endfunction

    initial begin
        // reset held with start high, then released with start low
        vecs.push_back(v(1,1,0,0, 7'b0000000, 0,0,0));
        vecs.push_back(v(1,1,0,0, 7'b0000000, 0,0,0));
        vecs.push_back(v(1,1,0,0, 7'b0000000, 0,0,0));
        vecs.push_back(v(0,0,0,0, 7'b0000000, 0,0,0));
        vecs.push_back(v(0,0,0,0, 7'b0000000, 0,0,0));
        // run A: a_msb 1,0,1,0 on the CHECK cycles 4,7,10,13
        vecs.push_back(v(0,1,0,0, 7'b0000000, 0,0,0)); // 0 IDLE, start
        vecs.push_back(v(0,0,0,0, 7'b1110000, 1,0,0)); // 1 LOAD
        vecs.push_back(v(0,0,0,0, 7'b0001000, 1,0,0)); // 2 SHIFT
        vecs.push_back(v(0,0,0,0, 7'b0000100, 1,0,0)); // 3 SUB
        vecs.push_back(v(0,0,0,1, 7'b0000010, 1,0,0)); // 4 CHECK restore
        vecs.push_back(v(0,0,0,0, 7'b0001000, 1,0,0)); // 5
        vecs.push_back(v(0,0,0,0, 7'b0000100, 1,0,0)); // 6
        vecs.push_back(v(0,0,0,0, 7'b0000001, 1,0,0)); // 7 CHECK set_q0
        vecs.push_back(v(0,0,0,0, 7'b0001000, 1,0,0)); // 8
        vecs.push_back(v(0,0,0,0, 7'b0000100, 1,0,0)); // 9
        vecs.push_back(v(0,0,0,1, 7'b0000010, 1,0,0)); // 10 CHECK restore
        vecs.push_back(v(0,0,0,0, 7'b0001000, 1,0,0)); // 11
        vecs.push_back(v(0,0,0,0, 7'b0000100, 1,0,0)); // 12
        vecs.push_back(v(0,0,0,0, 7'b0000001, 1,0,0)); // 13 CHECK set_q0
        vecs.push_back(v(0,0,0,0, 7'b0000000, 1,1,0)); // 14 DONE
        vecs.push_back(v(0,0,0,0, 7'b0000000, 0,0,0)); // 15 IDLE
        // run B: stray start pulses in cycles 5 and 9 are ignored
        vecs.push_back(v(0,1,0,0, 7'b0000000, 0,0,0)); // 0
        vecs.push_back(v(0,0,0,0, 7'b1110000, 1,0,0)); // 1
        vecs.push_back(v(0,0,0,0, 7'b0001000, 1,0,0)); // 2
        vecs.push_back(v(0,0,0,0, 7'b0000100, 1,0,0)); // 3
        vecs.push_back(v(0,0,0,0, 7'b0000001, 1,0,0)); // 4
        vecs.push_back(v(0,1,0,0, 7'b0001000, 1,0,0)); // 5 stray start
        vecs.push_back(v(0,0,0,0, 7'b0000100, 1,0,0)); // 6
        vecs.push_back(v(0,0,0,0, 7'b0000001, 1,0,0)); // 7
        vecs.push_back(v(0,0,0,0, 7'b0001000, 1,0,0)); // 8
        vecs.push_back(v(0,1,0,0, 7'b0000100, 1,0,0)); // 9 stray start
        vecs.push_back(v(0,0,0,0, 7'b0000001, 1,0,0)); // 10
        vecs.push_back(v(0,0,0,0, 7'b0001000, 1,0,0)); // 11
        vecs.push_back(v(0,0,0,0, 7'b0000100, 1,0,0)); // 12
        vecs.push_back(v(0,0,0,0, 7'b0000001, 1,0,0)); // 13
        vecs.push_back(v(0,0,0,0, 7'b0000000, 1,1,0)); // 14
        vecs.push_back(v(0,0,0,0, 7'b0000000, 0,0,0)); // 15

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].s, vecs[i].z, vecs[i].a);
            chk($sformatf("vec[%0d]", i), 32'(obs),
                32'({vecs[i].ctrl, vecs[i].busy, vecs[i].done, vecs[i].dbz}));
        end

        // back-to-back: start held high, second LOAD in cycle 16
        drive(0, 1, 0, 0);
        for (int c = 1; c <= 16; c++) begin
            drive(0, 1, 0, 0);
            if (c == 14) chk("b2b_done14", 32'(done), 32'(1));
            if (c == 15) chk("b2b_idle15", 32'(busy), 32'(0));
            if (c == 16) chk("b2b_load16", 32'(ctrl_o), 32'(7'b1110000));
        end
        wait_done("b2b_second_done", 13);

        // reset in cycle 8: IDLE next cycle, no done pulse afterwards
        drive(0, 1, 0, 0);
        for (int c = 1; c <= 7; c++) drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        begin
            logic saw_done = 1'b0;
            drive(0, 0, 0, 0);
            chk("rst_mid_idle", 32'(obs), 32'(0));
            for (int c = 0; c < 8; c++) begin
                drive(0, 0, 0, 0);
                saw_done |= done;
            end
            chk("rst_mid_no_done", 32'(saw_done), 32'(0));
        end
        drive(0, 1, 0, 0);
        wait_done("rst_mid_restart", 14);

        // divide by zero
        drive(0, 0, 0, 0);
        drive(0, 1, 1, 0);
        chk("dbz_c0", 32'(obs), 32'(10'b0000000_000));
        drive(0, 0, 0, 0);
        chk("dbz_c1", 32'(obs), 32'(10'b0000000_111));
        drive(0, 0, 0, 0);
        chk("dbz_c2", 32'(obs), 32'(10'b0000000_001));
        drive(0, 0, 0, 0);
        chk("dbz_hold", 32'(dbz), 32'(1));
        drive(0, 1, 0, 0);
        chk("dbz_start_c0", 32'(dbz), 32'(1));
        drive(0, 0, 0, 0);
        chk("dbz_clear_c1", 32'(obs), 32'(10'b1110000_100));
        wait_done("dbz_after_run", 13);

        // integration with the register datapath
        use_dp = 1'b1;
        dvd_bus = 4'd13; dsr_bus = 4'd3;
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        wait_done("int13_3_done", 14);
        chk("int13_3_q", 32'(dp_q), 32'(4));
        chk("int13_3_a", 32'(dp_a), 32'(1));

        dvd_bus = 4'd15; dsr_bus = 4'd1;
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        wait_done("int15_1_done", 14);
        chk("int15_1_q", 32'(dp_q), 32'(15));
        chk("int15_1_a", 32'(dp_a), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_controller.md
# div_controller

Sequencing FSM for the restoring-division datapath. It drives the load, clear, shift and add/subtract controls of the A (remainder), Q (dividend/quotient) and M (divisor) registers built from the 4-bit load-enable register. It accepts a start/done handshake from the system, counts WIDTH iterations and flags divide-by-zero without touching the datapath.

## Interface
- WIDTH, 4, operand width; sets the iteration count
- CW, $clog2(WIDTH+1), iteration counter width (derived, not overridden)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a division; sampled only in IDLE
- divisor_zero  in  1  combinational flag from the divisor input bus; sampled with start
- a_msb  in  1  sign bit of A after subtraction; sampled only in CHECK
- ld_m  out  1  load M from divisor bus
- ld_q  out  1  load Q from dividend bus
- clr_a  out  1  clear A to 0
- shift_aq  out  1  shift {A,Q} left by one
- sub_a  out  1  load A with A−M
- restore_a  out  1  load A with A+M
- set_q0  out  1  write 1 into Q[0]; Q[0] is otherwise 0 after the shift
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- dbz  out  1  divide-by-zero flag, registered

## Operation
- States: IDLE, LOAD, SHIFT, SUB, CHECK, DONE. The encoding lives in the package.
- IDLE:
  - start=1, divisor_zero=0: go to LOAD and clear dbz.
  - start=1, divisor_zero=1: go to DONE, set dbz, assert no datapath controls.
  - start=0: stay in IDLE.
- LOAD: assert ld_m, ld_q and clr_a together. Load cnt with WIDTH. Go to SHIFT.
- SHIFT: assert shift_aq. Go to SUB.
- SUB: assert sub_a. Go to CHECK.
- CHECK:
  - a_msb=1: assert restore_a; leave set_q0 low.
  - a_msb=0: assert set_q0.
  - In both cases decrement cnt. If cnt==1 before the decrement, go to DONE; otherwise go to SHIFT.
- DONE: assert done for exactly one cycle. Go to IDLE.
- Control outputs are decoded combinationally from state. restore_a and set_q0 additionally depend on a_msb (Mealy, CHECK only).
- At most one of shift_aq, sub_a and restore_a is high in any cycle.
- start outside IDLE is ignored; it is not queued.
- dbz holds its value until the next accepted start. An accepted start clears it on entering LOAD, or sets it on the divide-by-zero path.
- cnt never wraps. It reaches 0 only on the final CHECK→DONE transition and is reloaded in LOAD.

## Timing
- Reset: state=IDLE, cnt=0, dbz=0. All control outputs are 0, and busy=0, done=0.
- rst has priority over every transition. Asserting it mid-operation returns to IDLE on the next edge with no done pulse. Datapath contents are then undefined, and the system must restart.
- Normal division, with start sampled at edge 0:
  - LOAD in cycle 1.
  - SHIFT/SUB/CHECK triplets in cycles 2 to 3·WIDTH+1.
  - done in cycle 3·WIDTH+2; 14 for WIDTH=4.
  - IDLE in cycle 3·WIDTH+3. A new start can be accepted at the edge ending that cycle.
- Divide-by-zero: DONE in cycle 1 with dbz=1 and done=1, then IDLE in cycle 2.
- busy is high from cycle 1 through the DONE cycle inclusive.
- Quotient and remainder are valid in the datapath registers from the DONE cycle onward, and stay valid until the next LOAD.

## Structure
- Package div_ctrl_pkg holds:
  - the state enum (div_state_t), typed 3-bit;
  - a packed struct div_ctrl_t bundling ld_m, ld_q, clr_a, shift_aq, sub_a, restore_a, set_q0;
  - the constant for the default WIDTH.
- Sub-module iter_counter: a CW-bit down counter with load, decrement and an is_one output. The FSM instantiates it once.
- The FSM has one state register and a combinational next-state/output decode.

## Test plan
- Reset: hold rst for 3 cycles with start=1 → busy=0, done=0, dbz=0 and all controls 0. Release rst with start=0 → stays in IDLE.
- Control sequence: WIDTH=4, start at cycle 0, a_msb driven 1,0,1,0 on the four CHECK cycles →
  - ld_m, ld_q and clr_a only in cycle 1;
  - restore_a in cycles 4 and 10;
  - set_q0 in cycles 7 and 13;
  - done only in cycle 14;
  - busy high in cycles 1–14.
- Integration with 4-bit register datapath: dividend 13, divisor 3 → Q=4, A=1 at done. Then dividend 15, divisor 1 → Q=15, A=0.
- Divide-by-zero: start with divisor_zero=1 → done and dbz high in cycle 1, no control asserted. dbz stays 1 until the next valid start, then is 0 from cycle 1.
- Ignored start plus back-to-back: pulse start in cycles 5 and 9 of a run → no effect and done still at cycle 14. A start held high continuously → second LOAD in cycle 16.
- Reset mid-operation: assert rst in cycle 8 → IDLE at the next edge, no done pulse. A new start then completes normally in 14 cycles.
